// File: rtl/cmd_pkg.sv
// cmd_pkg: command byte constants, serializer state enum and button encoder
// shared by cmd_tx, uart_tx_core and the display module.
package cmd_pkg;

    localparam logic [7:0] CMD_GAS         = 8'h74;
    localparam logic [7:0] CMD_BRAKE       = 8'h76;
    localparam logic [7:0] CMD_LEFT        = 8'h77;
    localparam logic [7:0] CMD_RIGHT       = 8'h75;
    localparam logic [7:0] CMD_GAS_LEFT    = 8'h71;
    localparam logic [7:0] CMD_GAS_RIGHT   = 8'h70;
    localparam logic [7:0] CMD_BRAKE_LEFT  = 8'h73;
    localparam logic [7:0] CMD_BRAKE_RIGHT = 8'h72;
    localparam logic [7:0] NO_CMD          = 8'h00;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    // Brake overrides gas; left+right together cancel steering.
    function automatic logic [7:0] encode_cmd(input logic gas, input logic brake,
                                              input logic left, input logic right);
        logic l;
        logic r;
        l = left & ~right;
        r = right & ~left;
        return brake ? (l ? CMD_BRAKE_LEFT : r ? CMD_BRAKE_RIGHT : CMD_BRAKE)
             : gas   ? (l ? CMD_GAS_LEFT   : r ? CMD_GAS_RIGHT   : CMD_GAS)
             : l     ? CMD_LEFT
             : r     ? CMD_RIGHT
             : NO_CMD;
    endfunction

endpackage

// File: rtl/cmd_tx_if.sv
// cmd_tx_if: button inputs and UART/status outputs of cmd_tx.
//   btn_gas/brake/left/right : asynchronous active-high buttons
//   tx                       : UART line, 8N1, idle high
//   busy                     : frame on the line
//   last_cmd                 : most recently started command, 0x00 if none
interface cmd_tx_if;
    logic       btn_gas;
    logic       btn_brake;
    logic       btn_left;
    logic       btn_right;
    logic       tx;
    logic       busy;
    logic [7:0] last_cmd;

    modport master (output btn_gas, btn_brake, btn_left, btn_right,
                    input  tx, busy, last_cmd);
    modport slave  (input  btn_gas, btn_brake, btn_left, btn_right,
                    output tx, busy, last_cmd);
endinterface

// File: rtl/cmd_tx_uart_tx_core.sv
// uart_tx_core: 8N1 serializer, LSB first.
//   clk, reset_n : clock, synchronous active-low reset
//   start        : accepted only while idle; latches data
//   data         : byte to send
//   tx           : registered serial line, idle high
//   busy         : registered, high in START/DATA/STOP
module uart_tx_core
    import cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    idx, idx_nxt;
    logic [7:0]    frame_byte;
    logic          bit_done, tx_d;

    assign bit_done = cnt == CW'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            frame_byte <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= nxt != state ? '0 : cnt + 1'b1;
            idx   <= idx_nxt;
            if (state == IDLE && start)
                frame_byte <= data;
            tx    <= tx_d;
            busy  <= nxt != IDLE;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:  if (start) nxt = START;
            START: if (bit_done) nxt = DATA;
            DATA:  if (bit_done && idx == 3'd7) nxt = STOP;
            STOP:  if (bit_done) nxt = IDLE;
        endcase
    end

    // The bit index advances only inside DATA, so 7 -> 0 happens on DATA exit.
    // The line value is precomputed from the next state so tx stays a flop.
    always_comb begin
        idx_nxt = state == DATA && bit_done ? idx + 3'd1 : idx;
        tx_d    = nxt == DATA ? frame_byte[idx_nxt] : nxt != START;
    end

endmodule

// File: rtl/cmd_tx.sv
// cmd_tx: synchronizes four buttons, encodes them into a command byte and
// sends each new command once over UART.
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : cmd_tx_if.slave (buttons in; tx, busy, last_cmd out)
module cmd_tx
    import cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int SYNC_STAGES  = 2
) (
    input  logic     clk,
    input  logic     reset_n,
    cmd_tx_if.slave  bus
);

    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] btn;
    logic [7:0] cmd, last_cmd;
    logic       cmd_valid, start, busy;

    assign btn = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
            cmd       <= NO_CMD;
            cmd_valid <= 1'b0;
            last_cmd  <= NO_CMD;
        end else begin
            sync_q[0] <= {bus.btn_gas, bus.btn_brake, bus.btn_left, bus.btn_right};
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            cmd       <= encode_cmd(btn[3], btn[2], btn[1], btn[0]);
            cmd_valid <= encode_cmd(btn[3], btn[2], btn[1], btn[0]) != NO_CMD;
            // While idle, cmd is either a new command being started, the same
            // command already held, or NO_CMD (clears so a re-press resends).
            if (!busy)
                last_cmd <= cmd;
        end
    end

    assign start = cmd_valid && cmd != last_cmd && !busy;

    uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .data    (cmd),
        .tx      (bus.tx),
        .busy    (busy)
    );

    assign bus.busy     = busy;
    assign bus.last_cmd = last_cmd;

endmodule
